// File: rtl/lock_pkg.sv
// Shared types and parameter defaults for the lock code sender.
// No logic or latency of its own; no flow control.
package lock_pkg;

  localparam int MAX_LEN_DEF        = 8;
  localparam int PRESS_CYCLES_DEF   = 2;
  localparam int GAP_CYCLES_DEF     = 2;
  localparam int TIMEOUT_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } lock_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// Request/button bundle between a code requester/lock and the sender.
// Master drives start/code/len/unlock; slave returns the registered button and status outputs.
interface lock_code_sender_if #(
  parameter int MAX_LEN = lock_pkg::MAX_LEN_DEF
);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic               start;
  logic [MAX_LEN-1:0] code;
  logic [LW-1:0]      len;
  logic               unlock;
  logic               b0;
  logic               b1;
  logic               busy;
  logic               done;
  logic               ok;

  modport master (output start, code, len, unlock, input b0, b1, busy, done, ok);
  modport slave  (input start, code, len, unlock, output b0, b1, busy, done, ok);
endinterface

// File: rtl/lock_tx_timer.sv
// Loadable down-counter with a zero flag; load takes effect on the next edge.
// Counts down to zero and holds there; no flow control.
module lock_tx_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/lock_code_sender.sv
// Plays a latched code as timed b0/b1 presses, then waits for unlock; first press one cycle after start.
// All outputs registered; start/code/len are only sampled in IDLE, unlock only in WAIT.
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int MAX_LEN        = MAX_LEN_DEF,
  parameter int PRESS_CYCLES   = PRESS_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  lock_code_sender_if.slave  bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(max3(PRESS_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

  lock_state_e        state_q, state_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LW-1:0]      len_q, len_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic               b0_q, b0_d, b1_q, b1_d;
  logic               busy_q, busy_d, done_q, done_d, ok_q, ok_d;
  logic               t_load, t_zero;
  logic [TW-1:0]      t_val;
  logic               len_ok;
  logic [LW-1:0]      pos;
  logic               press_bit;

  lock_tx_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  assign len_ok = (bus.len != '0) && (bus.len <= LW'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    t_load  = 1'b0;
    t_val   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ok_d = 1'b0;
          if (len_ok) begin
            code_d  = bus.code;
            len_d   = bus.len;
            idx_d   = '0;
            state_d = ST_PRESS;
            t_load  = 1'b1;
            t_val   = TW'(PRESS_CYCLES - 1);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_PRESS: begin
        if (t_zero) begin
          state_d = ST_GAP;
          t_load  = 1'b1;
          t_val   = TW'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (t_zero) begin
          t_load = 1'b1;
          if (idx_q == len_q - LW'(1)) begin
            state_d = ST_WAIT;
            t_val   = TW'(TIMEOUT_CYCLES - 1);
          end else begin
            idx_d   = idx_q + LW'(1);
            state_d = ST_PRESS;
            t_val   = TW'(PRESS_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        // unlock wins over the timeout in the final wait cycle
        if (bus.unlock) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
        end else if (t_zero) begin
          state_d = ST_DONE;
          ok_d    = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    pos       = len_d - idx_d - LW'(1);
    press_bit = |(code_d & (MAX_LEN'(1) << pos));
    b1_d      = (state_d == ST_PRESS) && press_bit;
    b0_d      = (state_d == ST_PRESS) && !press_bit;
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      b0_q    <= 1'b0;
      b1_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
    end
  end

  assign bus.b0   = b0_q;
  assign bus.b1   = b1_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ok   = ok_q;
endmodule

// File: tb/tb_lock_code_sender.sv
// Randomized scoreboard bench for lock_code_sender with a sliding-window lock (0,1,0,1,1).
// Stimulus pushes expected presses/completion with cycle stamps; a negedge monitor pops and compares.
module tb_lock_code_sender;
  import lock_pkg::*;

  localparam int ML = MAX_LEN_DEF;
  localparam int P  = PRESS_CYCLES_DEF;
  localparam int G  = GAP_CYCLES_DEF;
  localparam int T  = TIMEOUT_CYCLES_DEF;
  localparam int LW = $clog2(ML + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lock_code_sender_if #(.MAX_LEN(ML)) bus();

  lock_code_sender #(
    .MAX_LEN(ML), .PRESS_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int at;
    bit val;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  busy_from = 1, busy_to = 0;
  int  ok_clear_cyc = -1, ok_set_cyc = -1;
  bit  ok_val = 1'b0;
  int  lock_dly = 0;
  bit  lock_noise = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Lock model: remembers presses of the current send, unlocks lock_dly cycles after a
  // release that completes 0,1,0,1,1; optional noise pulses only while a button is held.
  bit hist[$];
  int lock_cd = -1;
  bit prev_pr = 1'b0;
  always @(posedge clk) begin
    bit pr;
    int n;
    #1;
    pr = (bus.b0 === 1'b1) || (bus.b1 === 1'b1);
    if (bus.busy !== 1'b1) begin
      hist.delete();
      lock_cd    = -1;
      bus.unlock = 1'b0;
      pr         = 1'b0;
    end else if (pr) begin
      if (!prev_pr) hist.push_back(bus.b1);
      lock_cd    = -1;
      bus.unlock = lock_noise && ($urandom_range(1, 0) == 1);
    end else begin
      if (prev_pr) begin
        bus.unlock = 1'b0;
        n = hist.size();
        if (n >= 5 && hist[n-5] == 0 && hist[n-4] == 1 && hist[n-3] == 0 &&
            hist[n-2] == 1 && hist[n-1] == 1)
          lock_cd = lock_dly;
      end
      if (lock_cd == 0) begin
        bus.unlock = 1'b1;
        lock_cd    = -1;
      end else if (lock_cd > 0) begin
        lock_cd--;
      end
    end
    prev_pr = pr;
  end

  // Monitor
  bit rst_prev = 1'b1;
  int run_len = 0, run_start = 0;
  bit run_bit = 1'b0;
  bit ok_hold = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (rst_prev) begin
      check("reset_b0", bus.b0, 0);
      check("reset_b1", bus.b1, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_ok", bus.ok, 0);
      run_len = 0;
      ok_hold = 1'b0;
    end else begin
      check("b0_b1_exclusive", bus.b0 & bus.b1, 0);
      check("busy", bus.busy, int'(cyc >= busy_from && cyc <= busy_to));
      if (cyc == ok_set_cyc) ok_hold = ok_val;
      else if (cyc == ok_clear_cyc) ok_hold = 1'b0;
      check("ok_level", bus.ok, ok_hold);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 1, e.is_done);
          check("done_cycle", cyc, e.at);
          check("done_ok", bus.ok, e.val);
        end
      end
      if (bus.b0 || bus.b1) begin
        if (run_len == 0) begin
          run_start = cyc;
          run_bit   = bus.b1;
        end
        run_len++;
      end else if (run_len > 0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_press", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("press_kind", 0, e.is_done);
          check("press_bit", run_bit, e.val);
          check("press_start", run_start, e.at);
          check("press_len", run_len, P);
        end
        run_len = 0;
      end
    end
    rst_prev = reset;
  end

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input logic [ML-1:0] code, input int len, input int dly,
                         input bit junk, input int abort_after);
    int s, w, c, u, done_at;
    bit okv, match;
    ev_t e;
    @(posedge clk); #1;
    s          = cyc;
    bus.code   = code;
    bus.len    = LW'(len);
    bus.start  = 1'b1;
    lock_dly   = dly;
    lock_noise = junk;
    okv        = 1'b0;
    if (len < 1 || len > ML) begin
      done_at = s + 1;
    end else begin
      for (int i = 0; i < len; i++) begin
        e.is_done = 1'b0;
        e.at      = s + 1 + i * (P + G);
        e.val     = code[len-1-i];
        exp_q.push_back(e);
      end
      w       = s + 1 + len * (P + G);
      c       = s + 1 + (len - 1) * (P + G) + P;
      match   = (len >= 5) && (code[4:0] == 5'b01011);
      done_at = w + T;
      if (match) begin
        u = c + dly;
        if (u < w) u = w;
        if (u <= w + T - 1) begin
          done_at = u + 1;
          okv     = 1'b1;
        end
      end
    end
    e.is_done = 1'b1;
    e.at      = done_at;
    e.val     = okv;
    exp_q.push_back(e);
    busy_from    = s + 1;
    busy_to      = done_at;
    ok_clear_cyc = s + 1;
    ok_set_cyc   = done_at;
    ok_val       = okv;
    for (int n = s + 1; n <= done_at + 1; n++) begin
      @(posedge clk); #1;
      if (abort_after >= 0 && n == s + 1 + abort_after) begin
        reset      = 1'b1;
        bus.start  = 1'b0;
        exp_q.delete();
        busy_to    = n;
        ok_set_cyc = -1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (junk && n <= done_at) begin
        bus.start = ($urandom_range(1, 0) == 1);
        bus.code  = ML'($urandom);
        bus.len   = LW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [ML-1:0] rc;
    int rl;
    bus.start  = 1'b0;
    bus.code   = '0;
    bus.len    = '0;
    bus.unlock = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_txn(8'b0000_1011, 5, 0, 1'b0, -1);  // correct code, unlocks
    run_txn(8'b0000_1010, 5, 0, 1'b0, -1);  // wrong code, times out
    run_txn(8'hFF, 0, 0, 1'b0, -1);         // empty code
    run_txn(8'hFF, 9, 0, 1'b0, -1);         // too long
    run_txn(8'b0000_1011, 5, 5, 1'b0, -1);  // unlock in the last wait cycle
    run_txn(8'b0000_1011, 5, 6, 1'b0, -1);  // unlock one cycle too late
    run_txn(8'b1110_1011, 8, 1, 1'b0, -1);  // full length, match on last five
    run_txn(8'b0000_1011, 5, 0, 1'b1, -1);  // restarts and code/len churn while busy
    run_txn(8'b0000_1011, 5, 0, 1'b0, 9);   // reset during third press
    run_txn(8'b0000_1011, 5, 0, 1'b0, -1);  // clean run after reset

    for (int k = 0; k < 40; k++) begin
      rc = ML'($urandom);
      rl = $urandom_range(ML + 2, 0);
      if ($urandom_range(2, 0) == 0) begin
        rc[4:0] = 5'b01011;
        rl      = $urandom_range(ML, 5);
      end
      run_txn(rc, rl, $urandom_range(7, 0), 1'($urandom_range(1, 0)), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
